// File: rtl/snd_cmd_sched.sv
// snd_cmd_sched: sound-command queue, NMI sequencer and periodic INT for the sound Z80.
// Define SND_CMD_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise a single command latch.
module snd_cmd_sched #(
  parameter int INT_PERIOD = 40961,
  parameter int NMI_PULSE  = 96,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clkm_48MHZ,
  input  logic       SND_RST,
  input  logic       clk_en_1p5,
  input  logic       pause,
  input  logic       MAIN_CMD_WR,
  input  logic       MAIN_NMIEN_WR,
  input  logic [7:0] MAIN_DIN,
  input  logic       SND_CMD_RD,
  input  logic       SND_STAT_WR,
  input  logic       SND_NMI_MASK,
  input  logic       SND_INT_ACK,
  output logic [7:0] CMD_DATA,
  output logic [7:0] STATUS,
  output logic       MAIN_BUSY,
  output logic       NMI_n,
  output logic       INT_n
);
  typedef enum logic [1:0] {IDLE, PULSE, WAIT} state_t;
  state_t state_q, state_d;
  logic [7:0] pcnt_q, pcnt_d, cmd_q, head;
  logic [15:0] tmr_q;
  logic pend_q, busy_q, nmien_q, ovf_q, mask_q, popseen_q, popseen_d, ireq_q;
  logic nonempty, full, pop, ovf_set, tick, wrap;
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..16");
  end
`ifdef SND_CMD_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic push;
  assign nonempty = cnt_q != '0;
  assign full = cnt_q == (AW+1)'(FIFO_DEPTH);
  assign push = MAIN_CMD_WR & (~full | SND_CMD_RD);
  assign head = mem_q[rp_q];
  always_ff @(posedge clkm_48MHZ)
    if (push) mem_q[wp_q] <= MAIN_DIN;
  always_ff @(posedge clkm_48MHZ)
    if (SND_RST) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_q + AW'(push);
      rp_q  <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
`else
  logic [7:0] lat_q;
  logic val_q;
  assign nonempty = val_q;
  assign full = val_q;
  assign head = lat_q;
  always_ff @(posedge clkm_48MHZ)
    if (SND_RST) begin
      lat_q <= '0;
      val_q <= 1'b0;
    end else begin
      lat_q <= MAIN_CMD_WR ? MAIN_DIN : lat_q;
      val_q <= MAIN_CMD_WR | (val_q & ~pop);
    end
`endif
  assign pop = SND_CMD_RD & nonempty;
  assign ovf_set = MAIN_CMD_WR & full & ~SND_CMD_RD;
  assign tick = clk_en_1p5 & ~pause;
  assign wrap = tick & (tmr_q == 16'(INT_PERIOD - 1));
  always_ff @(posedge clkm_48MHZ)
    if (SND_RST) begin
      cmd_q   <= '0;
      pend_q  <= 1'b0;
      busy_q  <= 1'b0;
      nmien_q <= 1'b0;
      ovf_q   <= 1'b0;
      mask_q  <= 1'b1;
      tmr_q   <= '0;
      ireq_q  <= 1'b0;
    end else begin
      cmd_q   <= nonempty ? head : cmd_q;
      pend_q  <= nonempty;
      busy_q  <= full;
      nmien_q <= SND_STAT_WR ? 1'b0 : MAIN_NMIEN_WR ? MAIN_DIN[0] : nmien_q;
      ovf_q   <= ovf_set | (ovf_q & ~SND_STAT_WR);
      mask_q  <= SND_NMI_MASK;
      tmr_q   <= wrap ? '0 : tmr_q + 16'(tick);
      ireq_q  <= wrap | (ireq_q & ~SND_INT_ACK);
    end
  // The FSM sees the registered pending flag, so a pop is only honoured once it has settled.
  always_ff @(posedge clkm_48MHZ)
    if (SND_RST) begin
      state_q   <= IDLE;
      pcnt_q    <= '0;
      popseen_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pcnt_q    <= pcnt_d;
      popseen_q <= popseen_d;
    end
  always_comb begin
    state_d = state_q;
    pcnt_d = pcnt_q;
    popseen_d = (pop & (state_q != IDLE)) | (popseen_q & (state_q == PULSE));
    case (state_q)
      IDLE: if (pend_q & nmien_q & ~mask_q) begin
        state_d = PULSE;
        pcnt_d = '0;
      end
      PULSE: if (pcnt_q == 8'(NMI_PULSE - 1)) state_d = WAIT;
             else pcnt_d = pcnt_q + 8'd1;
      WAIT: state_d = popseen_q ? IDLE : WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign CMD_DATA = cmd_q;
  assign STATUS = {4'hF, pend_q, nmien_q, ovf_q, 1'b1};
  assign MAIN_BUSY = busy_q;
  assign NMI_n = state_q != PULSE;
  assign INT_n = ~ireq_q;
endmodule

// File: tb/tb_snd_cmd_sched.sv
// tb_snd_cmd_sched: directed vectors and hand-written sequences for snd_cmd_sched
// (INT_PERIOD = 4, NMI_PULSE = 96); follows SND_CMD_FIFO_EN like the design.
module tb_snd_cmd_sched;
  logic clk = 1'b0, rst = 1'b1, clk_en = 1'b0, pause = 1'b0, cmd_wr = 1'b0, nmien_wr = 1'b0;
  logic rd = 1'b0, stat_wr = 1'b0, mask = 1'b1, ack = 1'b0;
  logic [7:0] din = 8'h00;
  logic [7:0] cmd_data, status;
  logic busy, nmi_n, int_n;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  snd_cmd_sched #(.INT_PERIOD(4), .NMI_PULSE(96), .FIFO_DEPTH(4)) dut (
    .clkm_48MHZ(clk), .SND_RST(rst), .clk_en_1p5(clk_en), .pause(pause),
    .MAIN_CMD_WR(cmd_wr), .MAIN_NMIEN_WR(nmien_wr), .MAIN_DIN(din),
    .SND_CMD_RD(rd), .SND_STAT_WR(stat_wr), .SND_NMI_MASK(mask), .SND_INT_ACK(ack),
    .CMD_DATA(cmd_data), .STATUS(status), .MAIN_BUSY(busy), .NMI_n(nmi_n), .INT_n(int_n)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_nmi(input logic lvl, input int lim, input string name);
    int n = 0;
    while (nmi_n !== lvl && n < lim) begin
      step();
      n++;
    end
    chk(name, {31'd0, nmi_n}, {31'd0, lvl});
  endtask

`ifndef SND_CMD_FIFO_EN
  typedef struct packed {
    logic wr, nw, rd, sw;
    logic [7:0] din, stat, cmd;
    logic busy;
  } vec_t;
  vec_t tbl [18];
`endif

  initial begin
    int n;
`ifndef SND_CMD_FIFO_EN
    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'hF1, 8'h00, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF9, 8'h11, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 8'h22, 8'hFB, 8'h11, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFB, 8'h22, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b1, 8'h01, 8'hF9, 8'h22, 1'b1},
      '{1'b0, 1'b1, 1'b0, 1'b0, 8'h01, 8'hFD, 8'h22, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hFD, 8'h22, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF5, 8'h22, 1'b0},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF5, 8'h22, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'h33, 8'hF5, 8'h22, 1'b0},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFD, 8'h33, 1'b1},
      '{1'b1, 1'b0, 1'b1, 1'b0, 8'h44, 8'hFD, 8'h33, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFD, 8'h44, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b1, 8'h55, 8'hFB, 8'h44, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFB, 8'h55, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'hF9, 8'h55, 1'b1},
      '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'hF9, 8'h55, 1'b1},
      '{1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hF1, 8'h55, 1'b0}
    };
`endif
    repeat (2) step();
    rst = 1'b0;
    chk("rst_status", status, 8'hF1);
    chk("rst_cmd", cmd_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_nmi", nmi_n, 1'b1);
    chk("rst_int", int_n, 1'b1);
`ifdef SND_CMD_FIFO_EN
    nmien_wr = 1'b1; din = 8'h01; step(); nmien_wr = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      cmd_wr = 1'b1; din = 8'(i); step();
    end
    cmd_wr = 1'b0; step();
    chk("fifo_full_status", status, 8'hFF);
    chk("fifo_busy", busy, 1'b1);
    chk("fifo_head", cmd_data, 8'h01);
    mask = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      wait_nmi(1'b0, 10, "fifo_nmi_start");
      chk("fifo_order", cmd_data, i);
      wait_nmi(1'b1, 200, "fifo_nmi_end");
      rd = 1'b1; step(); rd = 1'b0; step();
    end
    n = 0;
    repeat (10) begin step(); if (nmi_n === 1'b0) n++; end
    chk("fifo_no_extra_nmi", n, 0);
    chk("fifo_drained_status", status, 8'hF7);
    chk("fifo_drained_busy", busy, 1'b0);
    stat_wr = 1'b1; step(); stat_wr = 1'b0;
    chk("fifo_stat_clear", status, 8'hF1);
    cmd_wr = 1'b1; rd = 1'b1; din = 8'hAA; step(); cmd_wr = 1'b0; rd = 1'b0; step();
    chk("fifo_wr_rd_empty", status, 8'hF9);
    chk("fifo_wr_rd_cmd", cmd_data, 8'hAA);
    rd = 1'b1; step(); rd = 1'b0; step();
    chk("fifo_count_was_1", status, 8'hF1);
    mask = 1'b1;
`else
    for (int i = 0; i < 18; i++) begin
      cmd_wr = tbl[i].wr; nmien_wr = tbl[i].nw; rd = tbl[i].rd; stat_wr = tbl[i].sw; din = tbl[i].din;
      step();
      chk($sformatf("vec%0d_status", i), status, tbl[i].stat);
      chk($sformatf("vec%0d_cmd", i), cmd_data, tbl[i].cmd);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("vec%0d_nmi", i), nmi_n, 1'b1);
    end
    cmd_wr = 1'b0; nmien_wr = 1'b0; rd = 1'b0; stat_wr = 1'b0;
`endif
    nmien_wr = 1'b1; din = 8'h01; step(); nmien_wr = 1'b0;
    cmd_wr = 1'b1; din = 8'h77; step(); cmd_wr = 1'b0; step();
    chk("mask_status", status, 8'hFD);
    chk("mask_cmd", cmd_data, 8'h77);
    n = 0;
    repeat (6) begin step(); if (nmi_n === 1'b0) n++; end
    chk("masked_no_nmi", n, 0);
    mask = 1'b0; step();
    chk("mask_fall_1", nmi_n, 1'b1);
    step();
    chk("mask_fall_2", nmi_n, 1'b0);
    wait_nmi(1'b1, 200, "mask_pulse_end");
    rd = 1'b1; step(); rd = 1'b0; step();
    chk("mask_pop_status", status, 8'hF5);
    cmd_wr = 1'b1; din = 8'h5A; step(); cmd_wr = 1'b0;
    chk("single_n0_nmi", nmi_n, 1'b1);
    chk("single_n0_status", status, 8'hF5);
    step();
    chk("single_n1_cmd", cmd_data, 8'h5A);
    chk("single_n1_status", status, 8'hFD);
    chk("single_n1_nmi", nmi_n, 1'b1);
    step();
    chk("single_n2_nmi", nmi_n, 1'b0);
    n = 0;
    while (nmi_n === 1'b0 && n < 300) begin n++; step(); end
    chk("nmi_width", n, 96);
    rd = 1'b1; step(); rd = 1'b0; step();
    chk("single_pop_status", status, 8'hF5);
    n = 0;
    repeat (120) begin step(); if (nmi_n === 1'b0) n++; end
    chk("no_second_nmi", n, 0);
    clk_en = 1'b1;
    repeat (3) begin step(); chk("int_pre_wrap", int_n, 1'b1); end
    step();
    chk("int_wrap1", int_n, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("int_ack", int_n, 1'b1);
    step(); chk("int_t2", int_n, 1'b1);
    step(); chk("int_t3", int_n, 1'b1);
    ack = 1'b1; step(); ack = 1'b0;
    chk("int_wrap_beats_ack", int_n, 1'b0);
    ack = 1'b1; step(); ack = 1'b0;
    chk("int_ack2", int_n, 1'b1);
    pause = 1'b1;
    n = 0;
    repeat (10) begin step(); if (int_n === 1'b0) n++; end
    chk("int_paused", n, 0);
    pause = 1'b0;
    step(); chk("int_resume_t2", int_n, 1'b1);
    step(); chk("int_resume_t3", int_n, 1'b1);
    step(); chk("int_after_pause", int_n, 1'b0);
    clk_en = 1'b0;
    cmd_wr = 1'b1; din = 8'h66; step(); din = 8'h67; step(); cmd_wr = 1'b0; step();
    chk("pre_rst_pulse", nmi_n, 1'b0);
    chk("pre_rst_int", int_n, 1'b0);
    repeat (5) step();
    rst = 1'b1; step();
    chk("mid_rst_nmi", nmi_n, 1'b1);
    chk("mid_rst_status", status, 8'hF1);
    chk("mid_rst_cmd", cmd_data, 8'h00);
    chk("mid_rst_int", int_n, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    step(); rst = 1'b0; step();
    chk("post_rst_nmi", nmi_n, 1'b1);
    chk("post_rst_status", status, 8'hF1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
